// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane selects.
package lsu_pkg;

  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ST_HI = 1'b1
  } lsu_state_e;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_B0   = 4'b0001;
  localparam logic [3:0] SEL_B1   = 4'b0010;
  localparam logic [3:0] SEL_B2   = 4'b0100;
  localparam logic [3:0] SEL_B3   = 4'b1000;
  localparam logic [3:0] SEL_W    = 4'b1111;

  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    logic [3:0] sel;
    case (lane)
      2'd0:    sel = SEL_B0;
      2'd1:    sel = SEL_B1;
      2'd2:    sel = SEL_B2;
      2'd3:    sel = SEL_B3;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-data lane extraction with sign or zero extension to 32 bits.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] mem_dout_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and extend it.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data_o = 32'h0000_0000;
    case (addr_lo_i)
      2'd0:    byte_s = mem_dout_i[7:0];
      2'd1:    byte_s = mem_dout_i[15:8];
      2'd2:    byte_s = mem_dout_i[23:16];
      2'd3:    byte_s = mem_dout_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = mem_dout_i[31:16];
    end else begin
      half_s = mem_dout_i[15:0];
    end
    case (size_i)
      SIZE_B:  data_o = {{24{~unsigned_i & byte_s[7]}}, byte_s};
      SIZE_H:  data_o = {{16{~unsigned_i & half_s[15]}}, half_s};
      default: data_o = mem_dout_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit in front of a word-organised data memory; halfword stores take two byte writes.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned/reserved requests with rsp_err.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_din,
  output logic              mem_we,
  output logic [3:0]        mem_sel,
  input  logic [XLEN-1:0]   mem_dout
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              lane_hi_q;
  logic [7:0]        hi_byte_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        size_eff_s;
  logic [1:0]        addr_lo_s;
  logic              err_s;
  logic [XLEN-1:0]   load_data_s;
  logic              unused_addr_hi_s;

  assign unused_addr_hi_s = ^req_addr[XLEN-1:ADDR_W+2];
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Alignment policy: either trap bad requests or force-align them.
  always_comb begin
    size_eff_s = req_size;
    addr_lo_s  = req_addr[1:0];
    err_s      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_size)
      SIZE_B:  err_s = 1'b0;
      SIZE_H:  err_s = req_addr[0];
      SIZE_W:  err_s = |req_addr[1:0];
      default: err_s = 1'b1;
    endcase
`else
    case (req_size)
      SIZE_B:  addr_lo_s = req_addr[1:0];
      SIZE_H:  addr_lo_s = {req_addr[1], 1'b0};
      default: begin
        size_eff_s = SIZE_W;
        addr_lo_s  = 2'b00;
      end
    endcase
`endif
  end

  lsu_load_ext u_load_ext (
    .mem_dout_i (mem_dout),
    .addr_lo_i  (addr_lo_s),
    .size_i     (size_eff_s),
    .unsigned_i (req_unsigned),
    .data_o     (load_data_s)
  );

  // Next state, memory drive and response for the cycle.
  always_comb begin
    state_d     = state_q;
    mem_addr    = {ADDR_W{1'b0}};
    mem_din     = {XLEN{1'b0}};
    mem_we      = 1'b0;
    mem_sel     = SEL_NONE;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_addr = req_addr[ADDR_W+1:2];
          if (err_s) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = {XLEN{1'b0}};
            rsp_err_d   = 1'b1;
          end else if (req_we) begin
            mem_we = 1'b1;
            case (size_eff_s)
              SIZE_B: begin
                mem_sel     = lane_sel(addr_lo_s);
                mem_din     = {4{req_wdata[7:0]}};
                rsp_valid_d = 1'b1;
                rsp_rdata_d = {XLEN{1'b0}};
                rsp_err_d   = 1'b0;
              end
              SIZE_H: begin
                mem_sel = lane_sel({addr_lo_s[1], 1'b0});
                mem_din = {4{req_wdata[7:0]}};
                state_d = ST_HI;
              end
              default: begin
                mem_sel     = SEL_W;
                mem_din     = req_wdata;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = {XLEN{1'b0}};
                rsp_err_d   = 1'b0;
              end
            endcase
          end else begin
            mem_sel     = SEL_W;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data_s;
            rsp_err_d   = 1'b0;
          end
        end else begin
          mem_sel = SEL_NONE;
        end
      end
      ST_HI: begin
        mem_addr    = addr_q;
        mem_sel     = lane_sel({lane_hi_q, 1'b1});
        mem_din     = {4{hi_byte_q}};
        mem_we      = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = {XLEN{1'b0}};
        rsp_err_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, held halfword upper byte and registered response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      lane_hi_q   <= 1'b0;
      hi_byte_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {XLEN{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (req_valid && (state_q == IDLE)) begin
        addr_q    <= req_addr[ADDR_W+1:2];
        lane_hi_q <= req_addr[1];
        hi_byte_q <= req_wdata[15:8];
      end else begin
        addr_q    <= addr_q;
        lane_hi_q <= lane_hi_q;
        hi_byte_q <= hi_byte_q;
      end
    end
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Load/store unit sitting directly upstream of the word-organised data memory (10-bit word address, 4-bit byte-lane select, combinational read).
- Accepts one byte/half/word load or store per request from the execute stage.
- Translates each request into memory word address, lane select and lane-replicated write data.
- Extracts and sign/zero-extends load data.
- The memory accepts only single-byte or full-word lane selects, so halfword stores are split into two byte writes over two cycles.

Parameters:
ADDR_W, 10, memory word-address width; mem_addr = req_addr[ADDR_W+1:2]
XLEN, 32, data width; fixed at 32, other values unsupported

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; equals (state==IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, low bits significant
rsp_valid  out  1  one-cycle completion pulse (loads and stores)
rsp_rdata  out  32  extended load data; 0 for stores
rsp_err  out  1  request rejected (misaligned/reserved size); valid with rsp_valid
mem_addr  out  ADDR_W  word address to memory
mem_din  out  32  write data, byte lanes replicated
mem_we  out  1  memory write enable
mem_sel  out  4  lane select: 0001/0010/0100/1000/1111 only
mem_dout  in  32  combinational memory read data

Behaviour:
- States: IDLE, ST_HI. Handshake fires on req_valid && req_ready.
- Reset (async, RST_N=0): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, held regs cleared. mem_we=0 unless a request is presented in IDLE.
- IDLE drive: mem_addr/mem_sel/mem_din/mem_we are combinational from the request (zero address/data, sel 0000, we 0 with no request).
- Aligned: byte any address; half addr[0]=0; word addr[1:0]=00.
- Store byte (SB): mem_sel = one-hot of addr[1:0]; mem_din = {4{wdata[7:0]}}; write at accept edge N; rsp_valid in cycle N+1.
- Store word (SW): mem_sel=1111, mem_din=wdata; write at N; rsp_valid in N+1.
- Store half (SH):
  - Low byte wdata[7:0] to lane {addr[1],0} at edge N; go to ST_HI.
  - In ST_HI: high byte wdata[15:8] (from held regs) to lane {addr[1],1} at edge N+1; return to IDLE.
  - rsp_valid in N+2; req_ready=0 during ST_HI.
- Loads: mem_we=0, mem_sel=1111.
  - mem_dout is captured at edge N: byte lane by addr[1:0], half by addr[1], word whole.
  - Capture is extended per req_unsigned; rsp_valid and rsp_rdata valid in N+1.
- Misaligned or size 11: no memory write; rsp_valid, rsp_err=1, rsp_rdata=0 in N+1.
- rsp_rdata/rsp_err hold until the next rsp_valid; rsp_valid deasserts after one cycle.
- Address bits above ADDR_W+1 are ignored (wrap).
- Reset asserted in ST_HI: high byte is not written; no rsp_valid is produced.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned half/word requests behave as above (rsp_err=1, no write).
- Undefined:
  - Misaligned addresses are silently force-aligned: half clears addr[0]; word clears addr[1:0].
  - The access proceeds normally with rsp_err tied 0.
  - Size 11 is treated as word in this mode.

Decomposition:
- lsu_pkg:
  - SIZE_B/SIZE_H/SIZE_W/SIZE_RSVD encodings.
  - State enum {IDLE, ST_HI}.
  - Lane-select constants SEL_B0..SEL_B3, SEL_W.
- Sub-module lsu_load_ext: combinational lane extraction plus sign/zero extension (inputs mem_dout, addr[1:0], size, unsigned; output 32-bit).

Test Plan:
- Store half: SW 0xDEADBEEF @0x10, then SH 0xA5C3 @0x12 → cycle1 mem_sel=0100 din=0xC3C3C3C3, cycle2 mem_sel=1000 din=0xA5A5A5A5; LW @0x10 → 0xA5C3BEEF; rsp_valid 2 cycles after SH accept; req_ready low 1 cycle.
- Signed byte loads: word@0x20=0x80FF7F01 → LB @0x23 → 0xFFFFFF80; LBU @0x23 → 0x00000080; LB @0x21 → 0x0000007F; each rsp_valid at N+1.
- Half extension: LH @0x22 of 0x80FF7F01 → 0xFFFF80FF; LHU → 0x000080FF.
- Misaligned (macro defined): SW 0x12345678 @0x31 → no mem_we pulse, rsp_err=1; LW @0x30 returns prior contents. Macro undefined: same SW writes @0x30, rsp_err=0.
- Reset during ST_HI: SH 0xBBAA @0x40 over word 0x00000000, drop RST_N in ST_HI → word 0x000000AA, rsp_valid never asserted, state IDLE, req_ready=1.
- Back-to-back: SB, LW, SB on consecutive cycles with req_valid held → one rsp_valid per request, each at N+1; the LW sees the first SB's data.
